// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the synchronous FIFO and a helper that
// derives the pointer width (address bits plus one wrap bit) from the depth.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  // Address bits needed for DEPTH entries, plus one wrap bit that tells a
  // full queue apart from an empty one when the address bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// fifo_ram: storage array for the synchronous FIFO.
// One synchronous write port and one asynchronous (combinational) read port.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, mem[raddr] with no latency
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int AW        = ptr_width(DEPTH) - 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage deliberately has no reset; the pointers alone define which
  // words are valid, and a reset-free array maps onto plain RAM/LUT cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // First-word fall-through: the head word is visible without a clock.
  assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock, first-word fall-through FIFO with
// occupancy count, full/empty/almost flags and overflow/underflow pulses.
// Ports:
//   clk           in   single clock, all state changes on rising edge
//   rst           in   asynchronous active-high reset (pointers, pulses)
//   clr           in   synchronous flush, overrides wr/rd
//   wr            in   push request
//   rd            in   pop request
//   wdata         in   push data
//   rdata         out  head-of-queue data, valid while empty=0
//   full          out  occupancy == DEPTH
//   empty         out  occupancy == 0
//   almost_full   out  occupancy >= AF_LEVEL
//   almost_empty  out  occupancy <= AE_LEVEL
//   count         out  occupancy, 0..DEPTH
//   overflow      out  one-cycle pulse after a rejected push
//   underflow     out  one-cycle pulse after a rejected pop
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int PW        = ptr_width(DEPTH),
  localparam int AW        = PW - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  // Parameter legality, checked once at elaboration.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "fifo_sync_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
    $fatal(1, "fifo_sync_param: AF_LEVEL must be in 1..DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_sync_param: AE_LEVEL must be in 1..DEPTH-1");
  end

  localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok;
  logic          pop_ok;

  // Status comes from the registered pointers only, never from wr/rd.
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                        (wptr_q[PW-1]   != rptr_q[PW-1]);
  // Modulo-2*DEPTH subtraction; the wrap bit makes DEPTH representable.
  assign count        = wptr_q - rptr_q;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign push_ok = wr && !full  && !clr;
  assign pop_ok  = rd && !empty && !clr;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clr) begin
      // Flush resets pointers only; stored words are left as they are.
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop_ok)  rptr_d = rptr_q + PW'(1);
      // A rejected request of one kind never blocks the other kind.
      overflow_d  = wr && full;
      underflow_d = rd && empty;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rdata)
  );

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: self-checking bench for fifo_sync_param with
// DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2. A vector table covers
// fill/drain/overflow/underflow; hand sequences cover wrap, flush and
// asynchronous reset. A data queue tracks accepted pushes and supplies the
// expected head word after every edge.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  fifo_sync_param #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wr           (wr),
    .rd           (rd),
    .wdata        (wdata),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, wr, rd;
    logic [7:0] wdata;
    int         cnt;
    logic       full, empty, af, ae, ovf, udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         m_count = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, w, r, input logic [7:0] d, input int cnt,
                              input logic f, e, af, ae, ov, ud);
    vec_t v;
    v.clr = c; v.wr = w; v.rd = r; v.wdata = d; v.cnt = cnt;
    v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = ov; v.udf = ud;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, let the edge happen, update the data queue,
  // and compare the head word whenever the queue holds data.
  task automatic step(input logic c, w, r, input logic [7:0] d);
    bit push_acc, pop_acc;
    @(negedge clk);
    clr = c; wr = w; rd = r; wdata = d;
    push_acc = w && !c && (m_count < 8);
    pop_acc  = r && !c && (m_count > 0);
    @(posedge clk);
    #1;
    if (c) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (pop_acc)  begin void'(sb.pop_front()); m_count--; end
      if (push_acc) begin sb.push_back(d); m_count++; end
    end
    if (sb.size() > 0) check("head rdata", rdata, sb[0]);
  endtask

  task automatic check_flags(input string tag, input int cnt,
                             input logic f, e, af, ae, ov, ud);
    check({tag, " count"},        count,        cnt);
    check({tag, " full"},         full,         f);
    check({tag, " empty"},        empty,        e);
    check({tag, " almost_full"},  almost_full,  af);
    check({tag, " almost_empty"}, almost_empty, ae);
    check({tag, " overflow"},     overflow,     ov);
    check({tag, " underflow"},    underflow,    ud);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // clr wr rd data  cnt f e af ae ov ud
    add(0,1,0,8'h10, 1,0,0,0,1,0,0);
    add(0,1,0,8'h11, 2,0,0,0,1,0,0);
    add(0,1,0,8'h12, 3,0,0,0,0,0,0);
    add(0,1,0,8'h13, 4,0,0,0,0,0,0);
    add(0,1,0,8'h14, 5,0,0,0,0,0,0);
    add(0,1,0,8'h15, 6,0,0,1,0,0,0);
    add(0,1,0,8'h16, 7,0,0,1,0,0,0);
    add(0,1,0,8'h17, 8,1,0,1,0,0,0);
    add(0,1,0,8'hAA, 8,1,0,1,0,1,0);   // rejected push
    add(0,0,0,8'h00, 8,1,0,1,0,0,0);   // pulse lasts one cycle
    add(0,0,1,8'h00, 7,0,0,1,0,0,0);
    add(0,0,1,8'h00, 6,0,0,1,0,0,0);
    add(0,0,1,8'h00, 5,0,0,0,0,0,0);
    add(0,0,1,8'h00, 4,0,0,0,0,0,0);
    add(0,0,1,8'h00, 3,0,0,0,0,0,0);
    add(0,0,1,8'h00, 2,0,0,0,1,0,0);
    add(0,0,1,8'h00, 1,0,0,0,1,0,0);
    add(0,0,1,8'h00, 0,0,1,0,1,0,0);
    add(0,1,1,8'h55, 1,0,0,0,1,0,1);   // pop rejected, push proceeds
    add(0,0,0,8'h00, 1,0,0,0,1,0,0);
    add(0,1,0,8'h60, 2,0,0,0,1,0,0);
    add(0,1,0,8'h61, 3,0,0,0,0,0,0);
    add(0,1,0,8'h62, 4,0,0,0,0,0,0);
    add(0,1,0,8'h63, 5,0,0,0,0,0,0);
    add(0,1,0,8'h64, 6,0,0,1,0,0,0);
    add(0,1,0,8'h65, 7,0,0,1,0,0,0);
    add(0,1,0,8'h66, 8,1,0,1,0,0,0);
    add(0,1,1,8'h77, 7,0,0,1,0,1,0);   // push rejected, pop proceeds
    add(0,0,0,8'h00, 7,0,0,1,0,0,0);

    // Reset state, during and after reset.
    #2;
    check_flags("in reset", 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_flags("after reset", 0, 0, 1, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
      check_flags($sformatf("v%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
                  vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf);
    end

    // Drain to three entries, then stream through the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h00);
      check($sformatf("drain%0d count", i), count, 6 - i);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 8'h80 + 8'(i));
      check($sformatf("wrap%0d count", i), count, 3);
      check($sformatf("wrap%0d overflow", i), overflow, 0);
      check($sformatf("wrap%0d underflow", i), underflow, 0);
    end

    // Flush at count 5 with a simultaneous push.
    step(0, 1, 0, 8'hA0);
    step(0, 1, 0, 8'hA1);
    check("pre-flush count", count, 5);
    step(1, 1, 0, 8'hEE);
    check_flags("flush", 0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 1, 8'h00);
    check_flags("flush+rd", 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 8'h00);
    check_flags("underflow", 0, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 8'h00);
    check_flags("underflow end", 0, 0, 1, 0, 1, 0, 0);

    // Asynchronous reset pulse between edges at count 4.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hC0 + 8'(i));
    check("pre-reset count", count, 4);
    @(negedge clk);
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
    #1 rst = 1'b1;
    #1 check_flags("async reset", 0, 0, 1, 0, 1, 0, 0);
    #1 rst = 1'b0;
    sb.delete();
    m_count = 0;
    step(0, 1, 0, 8'h3C);
    check("post-reset count", count, 1);
    check("post-reset rdata", rdata, 8'h3C);
    step(0, 0, 1, 8'h00);
    check_flags("post-reset pop", 0, 0, 1, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_sync_param
